// File: rtl/difftest_trace_arb_pkg.sv
// Shared difftest definitions: pipeline stage positions and the trace event record.
package difftest_def;

  localparam int NUMPOS     = 8;
  localparam int POS_W      = 3;
  localparam int SEQ_W_DEF  = 32;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [POS_W-1:0] {
    AT_fetch    = 3'd0,
    AT_decode   = 3'd1,
    AT_rename   = 3'd2,
    AT_dispatch = 3'd3,
    AT_issue    = 3'd4,
    AT_fu       = 3'd5,
    AT_lq       = 3'd6,
    AT_sq       = 3'd7
  } InstPos;

  typedef struct packed {
    InstPos               pos;
    logic [SEQ_W_DEF-1:0] seq;
  } trace_ev_t;

  // Saturating add used by the drop counter.
  function automatic logic [DROP_CNT_W-1:0] sat_add(logic [DROP_CNT_W-1:0] a,
                                                    logic [DROP_CNT_W-1:0] b);
    logic [DROP_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/difftest_ev_fifo.sv
// Per-stage event buffer: small FIFO of sequence numbers, push accepted when
// not full or when the head is popped in the same cycle.
module difftest_ev_fifo #(
  parameter int DEPTH = 2,
  parameter int SEQ_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [SEQ_W-1:0] din_i,
  output logic [SEQ_W-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SEQ_W-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Pointer width is exactly log2(DEPTH), so wrap comes for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/difftest_trace_arb.sv
// Collects per-stage difftest events into buffers and serialises them to a
// single trace sink with a round-robin arbiter that holds its grant under stall.
module difftest_trace_arb
  import difftest_def::*;
#(
  parameter int NUM_REQ = NUMPOS,
  parameter int DEPTH   = 2,
  parameter int SEQ_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           trace_en,
  input  logic [NUM_REQ-1:0]             ev_valid,
  input  logic [NUM_REQ-1:0][SEQ_W-1:0]  ev_seq,
  output logic                           out_valid,
  input  logic                           out_ready,
  output InstPos                         out_pos,
  output logic [SEQ_W-1:0]               out_seq,
  output logic [DROP_CNT_W-1:0]          drop_cnt,
  output logic                           overflow
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NDW   = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0]            empty, full, push, pop, drop;
  logic [NUM_REQ-1:0][SEQ_W-1:0] head;

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d, lock_idx_q, scan_idx, gnt;
  logic                  lock_q, scan_hit, any, xfer;
  logic [NDW-1:0]        n_drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  overflow_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    assign push[g] = trace_en && ev_valid[g];
    assign drop[g] = push[g] && full[g] && !pop[g];

    difftest_ev_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .din_i   (ev_seq[g]),
      .dout_o  (head[g]),
      .empty_o (empty[g]),
      .full_o  (full[g])
    );
  end

  // First non-empty port at or after rr_ptr, wrapping.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!scan_hit && !empty[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        scan_hit = 1'b1;
        scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign any  = ~&empty;
  assign gnt  = lock_q ? lock_idx_q : scan_idx;
  assign xfer = any && out_ready;
  assign pop  = xfer ? (NUM_REQ'(1) << gnt) : '0;

  assign rr_ptr_d = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_REQ; i++) n_drop = n_drop + NDW'(drop[i]);
  end

  assign drop_cnt_d = sat_add(drop_cnt_q, DROP_CNT_W'(n_drop));

  // A presented-but-stalled event keeps its grant even if earlier ports fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (xfer) rr_ptr_q <= rr_ptr_d;
      lock_q     <= any && !out_ready;
      lock_idx_q <= gnt;
      drop_cnt_q <= drop_cnt_d;
      if (|drop) overflow_q <= 1'b1;
    end
  end

  assign out_valid = any;
  assign out_pos   = any ? InstPos'(POS_W'(gnt)) : AT_fetch;
  assign out_seq   = any ? head[gnt] : '0;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_difftest_trace_arb.sv
// Bench for difftest_trace_arb: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_difftest_trace_arb;
  import difftest_def::*;

  localparam int N = 8;
  localparam int D = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  trace_en = 1'b0;
  logic                  out_ready = 1'b0;
  logic [N-1:0]          ev_valid = '0;
  logic [N-1:0][31:0]    ev_seq = '0;
  logic                  out_valid;
  InstPos                out_pos;
  logic [31:0]           out_seq;
  logic [15:0]           drop_cnt;
  logic                  overflow;

  difftest_trace_arb #(.NUM_REQ(N), .DEPTH(D), .SEQ_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .trace_en  (trace_en),
    .ev_valid  (ev_valid),
    .ev_seq    (ev_seq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_seq   (out_seq),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: one queue per stage, rr pointer, stalled-grant memory.
  int unsigned mq[N][$];
  int          m_rr = 0;
  int          m_lock = -1;
  int          m_drop = 0;
  bit          m_ovf = 1'b0;
  bit          m_ok = 1'b0;

  function automatic int m_pick();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < N; k++)
      if (mq[(m_rr + k) % N].size() > 0) return (m_rr + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int p;
    int nd;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; m_lock = -1; m_drop = 0; m_ovf = 1'b0; m_ok = 1'b1;
    end else if (m_ok) begin
      p = m_pick();
      m_lock = -1;
      if (p >= 0 && out_ready) begin
        void'(mq[p].pop_front());
        m_rr = (p + 1) % N;
      end else if (p >= 0) begin
        m_lock = p;
      end
      nd = 0;
      for (int i = 0; i < N; i++) begin
        if (trace_en && ev_valid[i]) begin
          if (mq[i].size() < D) mq[i].push_back(ev_seq[i]);
          else nd++;
        end
      end
      m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
      if (nd > 0) m_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    int p;
    if (m_ok) begin
      p = m_pick();
      chk("m_valid", out_valid, (p >= 0) ? 1 : 0);
      if (p >= 0) begin
        chk("m_pos", out_pos, p);
        chk("m_seq", out_seq, mq[p][0]);
      end else begin
        chk("m_pos_idle", out_pos, 0);
        chk("m_seq_idle", out_seq, 0);
      end
      chk("m_drop", drop_cnt, m_drop);
      chk("m_ovf", overflow, m_ovf);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    ev_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ev_valid = '0; out_ready = 1'b0; trace_en = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Single event, one-cycle latency.
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", overflow, 0);
    out_ready = 1'b1; ev_valid[2] = 1'b1; ev_seq[2] = 5;
    cyc();
    chk("t1_valid", out_valid, 1);
    chk("t1_pos", out_pos, 2);
    chk("t1_seq", out_seq, 5);
    cyc();
    chk("t1_after", out_valid, 0);

    // All ports at once drain in index order.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin ev_valid[i] = 1'b1; ev_seq[i] = i; end
    cyc();
    for (int i = 0; i < N; i++) begin
      chk("t2_pos", out_pos, i);
      chk("t2_seq", out_seq, i);
      cyc();
    end
    chk("t2_empty", out_valid, 0);
    chk("t2_drop", drop_cnt, 0);

    // Overflow with a stalled sink.
    do_reset();
    for (int s = 10; s <= 12; s++) begin
      ev_valid[5] = 1'b1; ev_seq[5] = s;
      cyc();
    end
    chk("t3_drop", drop_cnt, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_pos", out_pos, 5);
    chk("t3_seq", out_seq, 10);
    cyc(); cyc();
    chk("t3_hold", out_seq, 10);
    out_ready = 1'b1;
    cyc();
    chk("t3_next", out_seq, 11);
    cyc();
    chk("t3_empty", out_valid, 0);

    // Push into a full buffer while it is being popped.
    do_reset();
    ev_valid[6] = 1'b1; ev_seq[6] = 20; cyc();
    ev_valid[6] = 1'b1; ev_seq[6] = 21; cyc();
    chk("t4_head", out_seq, 20);
    out_ready = 1'b1; ev_valid[6] = 1'b1; ev_seq[6] = 22;
    cyc();
    chk("t4_drop", drop_cnt, 0);
    chk("t4_ovf", overflow, 0);
    chk("t4_seq1", out_seq, 21);
    cyc();
    chk("t4_seq2", out_seq, 22);
    cyc();
    chk("t4_empty", out_valid, 0);

    // Grant lock on the last port, then wrap to port 0.
    do_reset();
    ev_valid[7] = 1'b1; ev_seq[7] = 30; cyc();
    chk("t5_pos7", out_pos, 7);
    ev_valid[0] = 1'b1; ev_seq[0] = 40; cyc();
    chk("t5_lock", out_pos, 7);
    chk("t5_lock_seq", out_seq, 30);
    cyc();
    chk("t5_lock2", out_pos, 7);
    out_ready = 1'b1;
    cyc();
    chk("t5_wrap_pos", out_pos, 0);
    chk("t5_wrap_seq", out_seq, 40);
    cyc();
    chk("t5_empty", out_valid, 0);

    // Drop counter saturation, then reset mid-stream.
    do_reset();
    ev_valid = '1; cyc();
    ev_valid = '1; cyc();
    repeat (8191) begin ev_valid = '1; cyc(); end
    ev_valid = 8'h3F; cyc();
    chk("t6_fffe", drop_cnt, 16'hFFFE);
    ev_valid = 8'h07; cyc();
    chk("t6_sat", drop_cnt, 16'hFFFF);
    ev_valid = 8'h01; cyc();
    chk("t6_sat2", drop_cnt, 16'hFFFF);
    chk("t6_ovf", overflow, 1);
    rst = 1'b1; ev_valid = '1; out_ready = 1'b1;
    cyc();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_drop", drop_cnt, 0);
    chk("t6_rst_ovf", overflow, 0);
    rst = 1'b0;
    cyc();
    chk("t6_post_valid", out_valid, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      trace_en  = ($urandom_range(0, 9) != 0);
      out_ready = (n % 1000 < 500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      ev_valid  = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) ev_seq[i] = $urandom;
      cyc();
    end
    rst = 1'b0;
    trace_en = 1'b1;
    out_ready = 1'b1;
    repeat (20) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
